tick_generator: RTL and testbench
=================================

# tick_generator

Parametrised successor to the board-level free-running clock divider. It produces a free-running count plus CHANNELS independent, runtime-programmable tick channels. Each channel emits single-cycle clock-enable pulses and a matching square-wave phase, and can be run, halted or single-stepped. It sits at the DE1_SOC top level and drives slow-rate enables for the pipelined CPU, HEX refresh and LEDR blinkers. All logic runs on CLOCK_50; no derived clocks are generated.

## Interface
Parameters:
- WIDTH, 32: width of free_count, divisors and channel counters.
- CHANNELS, 4: number of tick channels (1..16).
- DEFAULT_DIV, 25_000_000: divisor loaded into every channel at reset.

Ports:
- clock  in  1  system clock (CLOCK_50).
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  configuration write strobe, one cycle.
- cfg_ch  in  $clog2(CHANNELS) (min 1)  target channel of cfg_we; values ≥ CHANNELS are ignored.
- cfg_div  in  WIDTH  new divisor D for cfg_ch.
- cfg_mode  in  2  new mode for cfg_ch: 0 RUN, 1 HALT, 2 STEP, 3 reserved (treated as HALT).
- step_req  in  1  single-cycle step pulse, applied to all channels in STEP mode.
- free_count  out  WIDTH  free-running count, +1 every cycle, wraps.
- tick  out  CHANNELS  registered single-cycle enable pulse per channel.
- phase  out  CHANNELS  registered square wave per channel; toggles on each tick.
- mode  out  2*CHANNELS  current mode per channel, readback.

## Operation
- Reset (synchronous, active-high) sets:
  - free_count = 0, all channel counters cnt = 0, tick = 0, phase = 0;
  - every divisor = DEFAULT_DIV, every mode = RUN.
- Effective terminal value per channel: Dm1 = max(D,1) − 1. D = 0 and D = 1 both tick every cycle.
- RUN mode, each edge:
  - if cnt ≥ Dm1: cnt ← 0, tick ← 1;
  - else: cnt ← cnt + 1, tick ← 0.
  - The ≥ comparison guarantees recovery if cnt ever exceeds Dm1.
- HALT mode: cnt holds, tick ← 0, phase holds.
- STEP mode:
  - cnt held at 0.
  - tick ← step_req, so exactly one tick per step_req cycle.
  - Back-to-back step_req cycles yield back-to-back ticks.
- phase ← phase ^ next_tick in every mode. This gives a 50% duty square wave of period 2·max(D,1) cycles in RUN.
- Configuration write (cfg_we = 1, cfg_ch valid):
  - divisor ← cfg_div, mode ← cfg_mode, cnt ← 0, tick ← 0, phase holds;
  - takes precedence over the channel's RUN/STEP behaviour in that cycle, so a coincident step_req is dropped for that channel only;
  - other channels are unaffected.
- Mode change HALT→RUN through a write restarts the count from 0. Counting does not resume from the held value.
- free_count is independent of all configuration and wraps 2^WIDTH−1 → 0.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- RUN with D after reset deasserts or after a config write: first tick is high in the cycle following the D-th rising edge, then every D cycles.
  - Example, D = 4: edges 1..3 advance cnt 0→3; edge 4 raises tick. Period is 4.
- STEP latency: step_req high in cycle n → tick high in cycle n+1.
- Config latency: cfg_we in cycle n → new mode and divisor govern the edge ending cycle n+1. tick is 0 in cycle n+1.
- Reset asserted mid-count: all state returns to reset values on the next edge. Any pending tick is lost and tick is 0 the cycle after.

## Structure
- Package tick_gen_pkg:
  - mode_t enum (MODE_RUN = 2'd0, MODE_HALT = 2'd1, MODE_STEP = 2'd2, MODE_RSVD = 2'd3);
  - DEFAULT_DIV default constant.
- Sub-module tick_channel holds one channel: divisor register, mode register, cnt, tick, phase, and the local write and step inputs.
  - Instantiated CHANNELS times in a generate loop.
  - cfg_ch decode lives in the top of tick_generator.
- The free_count counter lives directly in tick_generator.

## Test plan
- Reset, then run 12 cycles with WIDTH = 8, DEFAULT_DIV = 4 → tick[0] high in cycles 4, 8, 12 after release; phase[0] toggles at each tick; free_count = 12.
- Write D = 0 and then D = 1 to ch1 in RUN → tick[1] high every cycle from the second cycle after each write; phase[1] toggles every cycle.
- Set ch2 to STEP; pulse step_req at cycles 10, 11 and 20 → tick[2] high at cycles 11, 12 and 21 only; a RUN channel with D = 3 is unaffected.
- Set ch0 to HALT mid-count (cnt = 2, D = 4), wait 10 cycles, then write RUN with D = 4 → no ticks while halted; first tick 4 edges after the RUN write.
- cfg_we to ch3 coincident with step_req while ch3 is in STEP → no tick on ch3; ch2 in STEP ticks normally. Write with cfg_ch = CHANNELS → no channel changes.
- Assert reset for one cycle while the WIDTH = 8 free_count is at 255 → free_count = 0, all tick = 0, all modes read back 0 the next cycle.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// Shared definitions for the tick generator.
//   mode_t        : per-channel operating mode (RUN, HALT, STEP, reserved)
//   DEFAULT_DIV_C : divisor loaded into every channel at reset
//   sel_width()   : width of a channel-select field, never less than one bit
package tick_gen_pkg;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'd0,
    MODE_HALT = 2'd1,
    MODE_STEP = 2'd2,
    MODE_RSVD = 2'd3
  } mode_t;

  localparam int unsigned DEFAULT_DIV_C = 32'd25_000_000;

  function automatic int unsigned sel_width(input int unsigned n);
    if (n > 32'd1) begin
      return $clog2(n);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One programmable tick channel: divisor, mode, counter, tick pulse and phase.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   wr_en        : local configuration write (already decoded by the top)
//   wr_div       : divisor to load on wr_en
//   wr_mode      : mode to load on wr_en
//   step_req     : single-cycle step request, honoured only in STEP mode
//   tick         : registered single-cycle enable pulse
//   phase        : registered square wave, toggles on every tick
//   mode         : current mode readback
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_C
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_div,
  input  logic [1:0]       wr_mode,
  input  logic             step_req,
  output logic             tick,
  output logic             phase,
  output mode_t            mode
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1'b1);

  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] cnt_r;
  mode_t            mode_r;
  logic             tick_r;
  logic             phase_r;

  logic [WIDTH-1:0] dm1_s;
  logic [WIDTH-1:0] div_next_s;
  logic [WIDTH-1:0] cnt_next_s;
  mode_t            mode_next_s;
  logic             tick_next_s;
  logic             phase_next_s;

  // Terminal count: D = 0 behaves like D = 1 so the channel ticks every cycle.
  always_comb begin
    if (div_r == '0) begin
      dm1_s = '0;
    end else begin
      dm1_s = div_r - ONE;
    end
  end

  // Next-state logic; a local write overrides RUN/STEP behaviour this cycle.
  always_comb begin
    div_next_s  = div_r;
    mode_next_s = mode_r;
    cnt_next_s  = cnt_r;
    tick_next_s = 1'b0;
    if (wr_en) begin
      div_next_s  = wr_div;
      mode_next_s = mode_t'(wr_mode);
      cnt_next_s  = '0;
      tick_next_s = 1'b0;
    end else begin
      case (mode_r)
        MODE_RUN: begin
          // >= rather than == so a counter beyond the terminal value recovers.
          if (cnt_r >= dm1_s) begin
            cnt_next_s  = '0;
            tick_next_s = 1'b1;
          end else begin
            cnt_next_s  = cnt_r + ONE;
            tick_next_s = 1'b0;
          end
        end
        MODE_STEP: begin
          cnt_next_s  = '0;
          tick_next_s = step_req;
        end
        MODE_HALT, MODE_RSVD: begin
          cnt_next_s  = cnt_r;
          tick_next_s = 1'b0;
        end
        default: begin
          cnt_next_s  = cnt_r;
          tick_next_s = 1'b0;
        end
      endcase
    end
    phase_next_s = phase_r ^ tick_next_s;
  end

  // Channel state registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_r   <= DIV_RST;
      mode_r  <= MODE_RUN;
      cnt_r   <= '0;
      tick_r  <= 1'b0;
      phase_r <= 1'b0;
    end else begin
      div_r   <= div_next_s;
      mode_r  <= mode_next_s;
      cnt_r   <= cnt_next_s;
      tick_r  <= tick_next_s;
      phase_r <= phase_next_s;
    end
  end

  assign tick  = tick_r;
  assign phase = phase_r;
  assign mode  = mode_r;

endmodule

// File: rtl/tick_generator.sv
// Free-running counter plus CHANNELS independent programmable tick channels.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   cfg_we       : configuration write strobe
//   cfg_ch       : target channel; values >= CHANNELS select nothing
//   cfg_div      : new divisor for the target channel
//   cfg_mode     : new mode for the target channel
//   step_req     : step pulse broadcast to all channels
//   free_count   : free-running wrap-around count
//   tick         : per-channel registered enable pulse
//   phase        : per-channel registered square wave
//   mode         : per-channel mode readback, two bits per channel
module tick_generator
  import tick_gen_pkg::*;
#(
  parameter  int unsigned WIDTH       = 32,
  parameter  int unsigned CHANNELS    = 4,
  parameter  int unsigned DEFAULT_DIV = DEFAULT_DIV_C,
  localparam int unsigned CH_W        = sel_width(CHANNELS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [WIDTH-1:0]      cfg_div,
  input  logic [1:0]            cfg_mode,
  input  logic                  step_req,
  output logic [WIDTH-1:0]      free_count,
  output logic [CHANNELS-1:0]   tick,
  output logic [CHANNELS-1:0]   phase,
  output logic [2*CHANNELS-1:0] mode
);

  logic [WIDTH-1:0]    free_count_r;
  logic [CHANNELS-1:0] wr_en_s;
  mode_t               ch_mode_s [CHANNELS];

  // Free-running counter, independent of channel configuration.
  always_ff @(posedge clock) begin
    if (reset) begin
      free_count_r <= '0;
    end else begin
      free_count_r <= free_count_r + WIDTH'(1'b1);
    end
  end

  assign free_count = free_count_r;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    // Out-of-range cfg_ch values never match any channel index.
    assign wr_en_s[i] = cfg_we & (cfg_ch == CH_W'(i));

    tick_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_channel (
      .clock    (clock),
      .reset    (reset),
      .wr_en    (wr_en_s[i]),
      .wr_div   (cfg_div),
      .wr_mode  (cfg_mode),
      .step_req (step_req),
      .tick     (tick[i]),
      .phase    (phase[i]),
      .mode     (ch_mode_s[i])
    );

    assign mode[2*i +: 2] = ch_mode_s[i];
  end

endmodule

// File: tb/tb_tick_generator.sv
module tb_tick_generator;

  localparam int W  = 8;
  localparam int CH = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          cfg_we;
  logic [2:0]    cfg_ch;
  logic [W-1:0]  cfg_div;
  logic [1:0]    cfg_mode;
  logic          step_req;
  logic [W-1:0]  free_count;
  logic [CH-1:0] tick;
  logic [CH-1:0] phase;
  logic [9:0]    mode;

  int checks   = 0;
  int failures = 0;

  tick_generator #(
    .WIDTH       (W),
    .CHANNELS    (CH),
    .DEFAULT_DIV (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .cfg_mode   (cfg_mode),
    .step_req   (step_req),
    .free_count (free_count),
    .tick       (tick),
    .phase      (phase),
    .mode       (mode)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       we;
    logic [2:0] ch;
    logic [7:0] div;
    logic [1:0] md;
    logic       step;
    logic [4:0] mask;
    logic [4:0] etick;
    logic [4:0] ephase;
    logic [9:0] emode;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic we, input logic [2:0] ch,
                     input logic [7:0] div, input logic [1:0] md, input logic step,
                     input logic [4:0] mask, input logic [4:0] etick,
                     input logic [4:0] ephase, input logic [9:0] emode);
    vec_t v;
    v.rst = rst; v.we = we; v.ch = ch; v.div = div; v.md = md; v.step = step;
    v.mask = mask; v.etick = etick; v.ephase = ephase; v.emode = emode;
    vecs.push_back(v);
  endtask

  task automatic idl(input logic [4:0] m, input logic [4:0] t, input logic [4:0] p,
                     input logic [9:0] md);
    add(1'b0, 1'b0, 3'd0, 8'd0, 2'd0, 1'b0, m, t, p, md);
  endtask

  task automatic stp(input logic [4:0] m, input logic [4:0] t, input logic [4:0] p,
                     input logic [9:0] md);
    add(1'b0, 1'b0, 3'd0, 8'd0, 2'd0, 1'b1, m, t, p, md);
  endtask

  task automatic wr(input logic [2:0] ch, input logic [7:0] d, input logic [1:0] cm,
                    input logic [4:0] m, input logic [4:0] t, input logic [4:0] p,
                    input logic [9:0] md);
    add(1'b0, 1'b1, ch, d, cm, 1'b0, m, t, p, md);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic r, input logic we, input logic [2:0] ch,
                     input logic [7:0] d, input logic [1:0] m, input logic s);
    reset = r; cfg_we = we; cfg_ch = ch; cfg_div = d; cfg_mode = m; step_req = s;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] free_exp;
    vec_t v;
    free_exp = 8'd0;
    reset = 1'b1; cfg_we = 1'b0; cfg_ch = 3'd0; cfg_div = 8'd0; cfg_mode = 2'd0;
    step_req = 1'b0;

    // Reset then 12 cycles, every channel at default divisor 4.
    add(1'b1, 1'b0, 3'd0, 8'd0, 2'd0, 1'b0, 5'h1F, 5'h00, 5'h00, 10'h000);
    idl(5'h1F, 5'h00, 5'h00, 10'h000);
    idl(5'h1F, 5'h00, 5'h00, 10'h000);
    idl(5'h1F, 5'h00, 5'h00, 10'h000);
    idl(5'h1F, 5'h1F, 5'h1F, 10'h000);
    idl(5'h1F, 5'h00, 5'h1F, 10'h000);
    idl(5'h1F, 5'h00, 5'h1F, 10'h000);
    idl(5'h1F, 5'h00, 5'h1F, 10'h000);
    idl(5'h1F, 5'h1F, 5'h00, 10'h000);
    idl(5'h1F, 5'h00, 5'h00, 10'h000);
    idl(5'h1F, 5'h00, 5'h00, 10'h000);
    idl(5'h1F, 5'h00, 5'h00, 10'h000);
    idl(5'h1F, 5'h1F, 5'h1F, 10'h000);
    // ch1: D = 0 then D = 1, ticks every cycle, phase holds across the write.
    wr(3'd1, 8'd0, 2'd0, 5'h02, 5'h00, 5'h02, 10'h000);
    idl(5'h02, 5'h02, 5'h00, 10'h000);
    idl(5'h02, 5'h02, 5'h02, 10'h000);
    idl(5'h02, 5'h02, 5'h00, 10'h000);
    wr(3'd1, 8'd1, 2'd0, 5'h02, 5'h00, 5'h00, 10'h000);
    idl(5'h02, 5'h02, 5'h02, 10'h000);
    idl(5'h02, 5'h02, 5'h00, 10'h000);
    idl(5'h02, 5'h02, 5'h02, 10'h000);
    // ch2 STEP with three step pulses, ch0 RUN D = 3 alongside.
    add(1'b1, 1'b0, 3'd0, 8'd0, 2'd0, 1'b0, 5'h1F, 5'h00, 5'h00, 10'h000);
    wr(3'd2, 8'd7, 2'd2, 5'h05, 5'h00, 5'h00, 10'h020);
    wr(3'd0, 8'd3, 2'd0, 5'h05, 5'h00, 5'h00, 10'h020);
    idl(5'h05, 5'h00, 5'h00, 10'h020);
    idl(5'h05, 5'h00, 5'h00, 10'h020);
    idl(5'h05, 5'h01, 5'h01, 10'h020);
    idl(5'h05, 5'h00, 5'h01, 10'h020);
    idl(5'h05, 5'h00, 5'h01, 10'h020);
    idl(5'h05, 5'h01, 5'h00, 10'h020);
    stp(5'h05, 5'h04, 5'h04, 10'h020);
    stp(5'h05, 5'h04, 5'h00, 10'h020);
    idl(5'h05, 5'h01, 5'h01, 10'h020);
    idl(5'h05, 5'h00, 5'h01, 10'h020);
    idl(5'h05, 5'h00, 5'h01, 10'h020);
    idl(5'h05, 5'h01, 5'h00, 10'h020);
    idl(5'h05, 5'h00, 5'h00, 10'h020);
    idl(5'h05, 5'h00, 5'h00, 10'h020);
    idl(5'h05, 5'h01, 5'h01, 10'h020);
    idl(5'h05, 5'h00, 5'h01, 10'h020);
    stp(5'h05, 5'h04, 5'h05, 10'h020);
    idl(5'h05, 5'h01, 5'h04, 10'h020);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      cyc(v.rst, v.we, v.ch, v.div, v.md, v.step);
      free_exp = v.rst ? 8'd0 : free_exp + 8'd1;
      chk($sformatf("row%0d_tick", i), 32'(tick & v.mask), 32'(v.etick));
      chk($sformatf("row%0d_phase", i), 32'(phase & v.mask), 32'(v.ephase));
      chk($sformatf("row%0d_mode", i), 32'(mode), 32'(v.emode));
      chk($sformatf("row%0d_free", i), 32'(free_count), 32'(free_exp));
    end

    // HALT mid-count, then restart RUN from zero.
    cyc(1'b1, 1'b0, 3'd0, 8'd0, 2'd0, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 8'd0, 2'd0, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 8'd0, 2'd0, 1'b0);
    cyc(1'b0, 1'b1, 3'd0, 8'd4, 2'd1, 1'b0);
    chk("halt_write_tick", 32'(tick[0]), 32'd0);
    chk("halt_mode", 32'(mode[1:0]), 32'd1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 3'd0, 8'd0, 2'd0, 1'b0);
      chk($sformatf("halted_tick_%0d", i), 32'(tick[0]), 32'd0);
      chk($sformatf("halted_phase_%0d", i), 32'(phase[0]), 32'd0);
    end
    cyc(1'b0, 1'b1, 3'd0, 8'd4, 2'd0, 1'b0);
    chk("resume_write_tick", 32'(tick[0]), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 1'b0, 3'd0, 8'd0, 2'd0, 1'b0);
      chk($sformatf("resume_edge%0d_tick", i), 32'(tick[0]), (i == 4) ? 32'd1 : 32'd0);
    end
    chk("resume_phase", 32'(phase[0]), 32'd1);

    // Config write coincident with step, reserved mode, out-of-range channel.
    cyc(1'b0, 1'b1, 3'd2, 8'd9, 2'd2, 1'b0);
    cyc(1'b0, 1'b1, 3'd3, 8'd9, 2'd2, 1'b0);
    cyc(1'b0, 1'b1, 3'd4, 8'd1, 2'd0, 1'b0);
    cyc(1'b0, 1'b1, 3'd1, 8'd1, 2'd3, 1'b0);
    cyc(1'b0, 1'b1, 3'd3, 8'd5, 2'd2, 1'b1);
    chk("coinc_tick3", 32'(tick[3]), 32'd0);
    chk("coinc_tick2", 32'(tick[2]), 32'd1);
    chk("coinc_tick4", 32'(tick[4]), 32'd1);
    chk("rsvd_tick1", 32'(tick[1]), 32'd0);
    chk("coinc_mode", 32'(mode), 32'h0AC);
    cyc(1'b0, 1'b0, 3'd0, 8'd0, 2'd0, 1'b1);
    chk("step_after_tick", 32'(tick[3:1]), 32'b110);
    cyc(1'b0, 1'b1, 3'd5, 8'd0, 2'd1, 1'b0);
    chk("badch5_mode", 32'(mode), 32'h0AC);
    chk("badch5_tick4", 32'(tick[4]), 32'd1);
    chk("badch5_tick2", 32'(tick[2]), 32'd0);
    cyc(1'b0, 1'b1, 3'd7, 8'd0, 2'd1, 1'b0);
    chk("badch7_mode", 32'(mode), 32'h0AC);
    chk("badch7_tick4", 32'(tick[4]), 32'd1);

    // free_count wrap, then reset while it sits at 255.
    cyc(1'b1, 1'b0, 3'd0, 8'd0, 2'd0, 1'b0);
    chk("rst_free", 32'(free_count), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    cyc(1'b0, 1'b1, 3'd2, 8'd1, 2'd2, 1'b0);
    for (int i = 0; i < 254; i++) cyc(1'b0, 1'b0, 3'd0, 8'd0, 2'd0, 1'b0);
    chk("free_255", 32'(free_count), 32'd255);
    chk("mode_before_wrap", 32'(mode), 32'h020);
    cyc(1'b0, 1'b0, 3'd0, 8'd0, 2'd0, 1'b0);
    chk("free_wrap", 32'(free_count), 32'd0);
    for (int i = 0; i < 255; i++) cyc(1'b0, 1'b0, 3'd0, 8'd0, 2'd0, 1'b0);
    chk("free_255_again", 32'(free_count), 32'd255);
    cyc(1'b1, 1'b0, 3'd0, 8'd0, 2'd0, 1'b1);
    chk("late_rst_free", 32'(free_count), 32'd0);
    chk("late_rst_tick", 32'(tick), 32'd0);
    chk("late_rst_phase", 32'(phase), 32'd0);
    chk("late_rst_mode", 32'(mode), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
